dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-back, write-allocate data cache sitting between the pipeline's MEM stage and the RAM arbiter. It responds to the dmemREN/dmemWEN/dmemaddr/dmemstore requests launched from the EX/MEM latch and returns dhit/dmemload. On halt it writes every dirty line back to RAM and then raises flushed.

## Interface
- SETS, 16, number of one-word lines; power of two, ≥2. IDX_W = log2(SETS); tag = dmemaddr[31:2+IDX_W]; index = dmemaddr[1+IDX_W:2]; bits [1:0] ignored.
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- dmemREN  in  1  pipeline read request
- dmemWEN  in  1  pipeline write request
- dmemaddr  in  32  request byte address (word-aligned)
- dmemstore  in  32  write data
- halt  in  1  pipeline halted; starts flush
- dhit  out  1  request completes this cycle
- dmemload  out  32  read data, valid when dhit=1
- flushed  out  1  flush complete, sticky until reset
- ramREN  out  1  RAM read
- ramWEN  out  1  RAM write
- ramaddr  out  32  RAM word address, bits [1:0]=0
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramwait  in  1  1 = RAM busy; 0 = access completes this cycle

## Operation
- Per-line state: valid, dirty, tag, 32-bit data. Reset clears all of them to 0.
- States: IDLE, WB, FILL, FLUSH, HALTED. Reset → IDLE.
- IDLE:
  - If halt=1, go to FLUSH with counter=0. Halt overrides any request, and dhit=0.
  - Else, if a request is present and valid[index] && tag matches: dhit=1 combinationally.
    - Write hit: data←dmemstore and dirty←1 at the edge.
    - If dmemREN=dmemWEN=1, the request is a write.
  - Else, on a miss: dhit=0. Go to WB if the victim line is valid&dirty, else go to FILL.
- WB:
  - Drive ramWEN=1, ramaddr={victim tag, index, 2'b00}, ramstore=victim data.
  - When ramwait=0: dirty←0, go to FILL.
- FILL:
  - Drive ramREN=1, ramaddr={dmemaddr[31:2], 2'b00}.
  - When ramwait=0: data←ramload, tag←request tag, valid←1, dirty←0, go to IDLE.
  - The request is re-evaluated in IDLE and hits. A write miss then applies its write as a write hit.
- FLUSH:
  - If line[counter] is valid&dirty, issue a WB-style RAM write. When ramwait=0: dirty←0, counter++.
  - Otherwise counter++ in one cycle with no RAM access.
  - After counter=SETS-1 completes, go to HALTED.
- HALTED: flushed=1. Requests are ignored (dhit=0, no RAM traffic). Only reset exits this state.
- halt is sampled only in IDLE. A miss in progress completes first, and the flush starts from IDLE on the following edge.
- The pipeline holds the request stable while dhit=0. The cache does not latch the request.
- dmemload = data[index] at all times. It is only meaningful when dhit=1.
- ramREN/ramWEN/ramaddr/ramstore are 0 in IDLE and HALTED, and also in FLUSH cycles that skip a clean line. ramREN and ramWEN are never both 1.

## Timing
- Reset values: dhit=0, dmemload=0, flushed=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0. Reset applies asynchronously at any state.
- Reset during WB/FILL/FLUSH aborts the RAM access immediately. Dirty data is lost.
- Hit: dhit in the same cycle as the request. No RAM access.
- Clean miss, request in cycle 0:
  - FILL in cycle 1. ramwait=0 in cycle 1+w ends FILL.
  - dhit in cycle 2+w.
- Dirty miss: WB occupies cycles 1..1+w1, then FILL, then dhit. Total = 3+w1+w2 cycles.
- Flush: 1 cycle per clean line, 1+w cycles per dirty line. flushed rises the cycle after the last line is processed.

## Test plan
- Read miss then hit: reset, read 0x100, ramload=0xDEADBEEF, ramwait high for 2 cycles.
  - Expect ramREN=1 and ramaddr=0x100 for 3 cycles, dhit=1 with dmemload=0xDEADBEEF in cycle 4.
  - Re-read 0x100: dhit in the same cycle, ramREN=0.
- Write hit: write 0x12345678 to 0x100.
  - Expect dhit in the same cycle and no RAM write.
  - Read 0x100 returns 0x12345678.
- Dirty conflict miss: after the write hit above, read 0x140 (index 0).
  - Expect a RAM write with ramaddr=0x100, ramstore=0x12345678.
  - Then ramREN with ramaddr=0x140, then dhit with the ramload value.
- Flush: dirty lines at indexes 2 and 7, then assert halt.
  - Expect exactly two RAM writes, in index order 2 then 7.
  - flushed=1 after index 15. A read issued afterwards gets dhit=0 and causes no RAM activity.
- Reset mid-WB: assert nRST=0 while in WB with ramwait=1.
  - ramWEN drops immediately and all outputs take their reset values.
  - A subsequent read of the former address misses (ramREN=1).
- Simultaneous REN and WEN on a hit: the line is written with dmemstore, dirty=1, dhit=1.

Source files
------------

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache between the MEM stage and the RAM arbiter.
// One-word lines; on halt every dirty line is written back to RAM before flushed is raised.
module dcache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramwait
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB     = 3'd1,
        FILL   = 3'd2,
        FLUSH  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [IDX_W-1:0]  cnt_r;
    logic [SETS-1:0]   valid_r;
    logic [SETS-1:0]   dirty_r;
    logic [TAG_W-1:0]  tag_r  [SETS];
    logic [31:0]       data_r [SETS];

    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  req_tag_s;
    logic              req_s;
    logic              hit_s;
    logic              victim_dirty_s;
    logic              flush_dirty_s;
    logic              ram_done_s;
    logic              flush_step_s;
    logic              write_hit_s;
    logic              unused_s;

    assign idx_s          = dmemaddr[1+IDX_W:2];
    assign req_tag_s      = dmemaddr[31:2+IDX_W];
    assign req_s          = dmemREN | dmemWEN;
    assign hit_s          = valid_r[idx_s] && (tag_r[idx_s] == req_tag_s);
    assign victim_dirty_s = valid_r[idx_s] & dirty_r[idx_s];
    assign flush_dirty_s  = valid_r[cnt_r] & dirty_r[cnt_r];
    assign ram_done_s     = ~ramwait;
    // A clean line in the flush walk advances without touching RAM.
    assign flush_step_s   = (state_r == FLUSH) && (!flush_dirty_s || ram_done_s);
    assign write_hit_s    = (state_r == IDLE) && !halt && dmemWEN && hit_s;
    assign unused_s       = ^dmemaddr[1:0];

    assign dmemload = data_r[idx_s];
    assign flushed  = (state_r == HALTED);

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Flush line counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_r <= {IDX_W{1'b0}};
        end else if (state_r == IDLE && halt) begin
            cnt_r <= {IDX_W{1'b0}};
        end else if (flush_step_s) begin
            cnt_r <= cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (halt) begin
                    next_state_s = FLUSH;
                end else if (req_s && !hit_s) begin
                    if (victim_dirty_s) begin
                        next_state_s = WB;
                    end else begin
                        next_state_s = FILL;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WB: begin
                if (ram_done_s) begin
                    next_state_s = FILL;
                end else begin
                    next_state_s = WB;
                end
            end
            FILL: begin
                if (ram_done_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = FILL;
                end
            end
            FLUSH: begin
                if (flush_step_s && (cnt_r == LAST_IDX)) begin
                    next_state_s = HALTED;
                end else begin
                    next_state_s = FLUSH;
                end
            end
            HALTED: begin
                next_state_s = HALTED;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output decode: pipeline handshake and RAM request
    always_comb begin
        dhit     = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        case (state_r)
            IDLE: begin
                if (!halt && req_s && hit_s) begin
                    dhit = 1'b1;
                end else begin
                    dhit = 1'b0;
                end
            end
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = {tag_r[idx_s], idx_s, 2'b00};
                ramstore = data_r[idx_s];
            end
            FILL: begin
                ramREN  = 1'b1;
                ramaddr = {dmemaddr[31:2], 2'b00};
            end
            FLUSH: begin
                if (flush_dirty_s) begin
                    ramWEN   = 1'b1;
                    ramaddr  = {tag_r[cnt_r], cnt_r, 2'b00};
                    ramstore = data_r[cnt_r];
                end else begin
                    ramWEN   = 1'b0;
                end
            end
            HALTED: begin
                dhit = 1'b0;
            end
            default: begin
                dhit = 1'b0;
            end
        endcase
    end

    // Line storage: write hits, fills and write-back clean-up
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_r <= {SETS{1'b0}};
            dirty_r <= {SETS{1'b0}};
            for (int i = 0; i < SETS; i++) begin
                tag_r[i]  <= {TAG_W{1'b0}};
                data_r[i] <= 32'd0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (write_hit_s) begin
                        data_r[idx_s]  <= dmemstore;
                        dirty_r[idx_s] <= 1'b1;
                    end
                end
                WB: begin
                    if (ram_done_s) begin
                        dirty_r[idx_s] <= 1'b0;
                    end
                end
                FILL: begin
                    if (ram_done_s) begin
                        data_r[idx_s]  <= ramload;
                        tag_r[idx_s]   <= req_tag_s;
                        valid_r[idx_s] <= 1'b1;
                        dirty_r[idx_s] <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_dirty_s && ram_done_s) begin
                        dirty_r[cnt_r] <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed vector table, hand-written flush/reset sequences,
// and a randomized run scored against a transaction-level cache/memory model.
module tb_dcache;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0;
    logic [31:0] dmemaddr = 32'd0, dmemstore = 32'd0;
    logic        dhit, flushed, ramREN, ramWEN;
    logic [31:0] dmemload, ramaddr, ramstore;
    logic [31:0] ramload = 32'd0;
    logic        ramwait = 1'b1;

    dcache dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramwait(ramwait)
    );

    always #5 CLK = ~CLK;

    // ---------------- RAM model (sole writer of its state) ----------------
    int          lat = 0;             // -1 = random latency per access
    logic        mem_clear = 1'b0;
    logic        force_ld = 1'b0;
    logic [31:0] force_val = 32'd0;
    logic [31:0] mem [256];
    int          wr_cnt = 0, rd_cnt = 0, ren_cycles = 0;
    logic [31:0] wr_addr [4096];
    logic [31:0] wr_data [4096];
    int          wr_lat  [4096];
    logic [31:0] rd_addr [4096];
    int          rd_lat  [4096];
    logic        both_seen = 1'b0;
    int          busy = 0, cur_lat = 0;
    logic        in_acc = 1'b0;

    function automatic logic [31:0] pat(input int w);
        return 32'hC0DE_0000 | 32'(w);
    endfunction

    always @(negedge CLK) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] = pat(i);
        end
        if (ramREN && ramWEN) both_seen = 1'b1;
        if (ramREN) ren_cycles++;
        if (!nRST || !(ramREN || ramWEN)) begin
            in_acc = 1'b0;
            busy = 0;
            ramwait = 1'b1;
        end else begin
            if (!in_acc) begin
                in_acc = 1'b1;
                busy = 0;
                cur_lat = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            end
            if (busy < cur_lat) begin
                ramwait = 1'b1;
                busy++;
            end else begin
                ramwait = 1'b0;
                in_acc = 1'b0;
                if (ramWEN) begin
                    mem[ramaddr[9:2]] = ramstore;
                    wr_addr[wr_cnt] = ramaddr;
                    wr_data[wr_cnt] = ramstore;
                    wr_lat[wr_cnt] = cur_lat;
                    wr_cnt++;
                end else begin
                    rd_addr[rd_cnt] = ramaddr;
                    rd_lat[rd_cnt] = cur_lat;
                    rd_cnt++;
                end
            end
        end
        ramload = force_ld ? force_val : mem[ramaddr[9:2]];
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        mem_clear = 1'b1;
        @(negedge CLK);
        mem_clear = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Present one request and hold it until dhit; cyc is the cycle of dhit (0 = same cycle).
    task automatic do_req(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] store, output int cyc, output logic [31:0] load);
        @(negedge CLK);
        dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = store;
        cyc = 0;
        load = 32'd0;
        forever begin
            #1;
            if (dhit) begin
                load = dmemload;
                break;
            end
            cyc++;
            if (cyc > 200) begin
                n_checks++; n_err++;
                $display("FAIL req_timeout: got no dhit for addr %h expected dhit within 200 cycles", addr);
                break;
            end
            @(negedge CLK);
        end
    endtask

    typedef struct {
        logic        ren, wen;
        logic [31:0] addr, store;
        int          lat;
        logic        frc;
        int          exp_cyc;
        logic        chk_load;
        logic [31:0] exp_load;
        int          exp_wr;
        logic [31:0] exp_wr_addr, exp_wr_data;
        int          exp_rd;
        int          exp_ren_cyc;
    } vec_t;

    vec_t vecs [11];

    // reference model state for the randomized run
    logic        m_valid [16];
    logic        m_dirty [16];
    int          m_tag   [16];
    logic [31:0] ref_mem [256];

    initial begin
        int cyc, wr0, rd0, rc0, fl_cyc, bad;
        logic [31:0] load;

        vecs[0]  = '{1'b1, 1'b0, 32'h100, 32'h0,         2, 1'b1, 4, 1'b1, 32'hDEADBEEF, 0, 32'h0, 32'h0, 1, 3};
        vecs[1]  = '{1'b1, 1'b0, 32'h100, 32'h0,         0, 1'b0, 0, 1'b1, 32'hDEADBEEF, 0, 32'h0, 32'h0, 0, 0};
        vecs[2]  = '{1'b0, 1'b1, 32'h100, 32'h12345678,  0, 1'b0, 0, 1'b0, 32'h0,        0, 32'h0, 32'h0, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 32'h100, 32'h0,         0, 1'b0, 0, 1'b1, 32'h12345678, 0, 32'h0, 32'h0, 0, 0};
        vecs[4]  = '{1'b1, 1'b0, 32'h140, 32'h0,         1, 1'b0, 5, 1'b1, pat(32'h50),  1, 32'h100, 32'h12345678, 1, 2};
        vecs[5]  = '{1'b1, 1'b1, 32'h140, 32'hCAFEF00D,  0, 1'b0, 0, 1'b0, 32'h0,        0, 32'h0, 32'h0, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 32'h140, 32'h0,         0, 1'b0, 0, 1'b1, 32'hCAFEF00D, 0, 32'h0, 32'h0, 0, 0};
        vecs[7]  = '{1'b1, 1'b0, 32'h180, 32'h0,         0, 1'b0, 3, 1'b1, pat(32'h60),  1, 32'h140, 32'hCAFEF00D, 1, 1};
        vecs[8]  = '{1'b0, 1'b1, 32'h108, 32'h11112222,  0, 1'b0, 2, 1'b0, 32'h0,        0, 32'h0, 32'h0, 1, 1};
        vecs[9]  = '{1'b0, 1'b1, 32'h11C, 32'h33334444,  3, 1'b0, 5, 1'b0, 32'h0,        0, 32'h0, 32'h0, 1, 4};
        vecs[10] = '{1'b1, 1'b0, 32'h11C, 32'h0,         0, 1'b0, 0, 1'b1, 32'h33334444, 0, 32'h0, 32'h0, 0, 0};

        // reset values while nRST is held low
        mem_clear = 1'b1;
        #2;
        check("rst_dhit", {31'd0, dhit}, 32'd0);
        check("rst_dmemload", dmemload, 32'd0);
        check("rst_flushed", {31'd0, flushed}, 32'd0);
        check("rst_ramREN", {31'd0, ramREN}, 32'd0);
        check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        apply_reset();

        // directed vector table
        for (int i = 0; i < 11; i++) begin
            wr0 = wr_cnt; rd0 = rd_cnt; rc0 = ren_cycles;
            lat = vecs[i].lat;
            force_ld = vecs[i].frc;
            force_val = 32'hDEADBEEF;
            do_req(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].store, cyc, load);
            check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            if (vecs[i].chk_load) check($sformatf("v%0d_load", i), load, vecs[i].exp_load);
            check($sformatf("v%0d_wr_count", i), 32'(wr_cnt - wr0), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr > 0) begin
                check($sformatf("v%0d_wr_addr", i), wr_addr[wr0], vecs[i].exp_wr_addr);
                check($sformatf("v%0d_wr_data", i), wr_data[wr0], vecs[i].exp_wr_data);
            end
            check($sformatf("v%0d_rd_count", i), 32'(rd_cnt - rd0), 32'(vecs[i].exp_rd));
            if (vecs[i].exp_rd > 0) check($sformatf("v%0d_rd_addr", i), rd_addr[rd0], vecs[i].addr);
            check($sformatf("v%0d_ren_cycles", i), 32'(ren_cycles - rc0), 32'(vecs[i].exp_ren_cyc));
            @(negedge CLK);
            force_ld = 1'b0;
            dmemREN = 1'b0; dmemWEN = 1'b0;
        end

        // flush: dirty lines at indexes 2 and 7 only
        wr0 = wr_cnt; rd0 = rd_cnt;
        lat = 1;
        halt = 1'b1;
        cyc = 0; fl_cyc = -1;
        while (cyc < 100) begin
            #1;
            if (flushed) begin
                fl_cyc = cyc;
                break;
            end
            cyc++;
            @(negedge CLK);
        end
        check("flush_cycles", 32'(fl_cyc), 32'd19);
        check("flush_wr_count", 32'(wr_cnt - wr0), 32'd2);
        check("flush_wr0_addr", wr_addr[wr0], 32'h108);
        check("flush_wr0_data", wr_data[wr0], 32'h11112222);
        check("flush_wr1_addr", wr_addr[wr0 + 1], 32'h11C);
        check("flush_wr1_data", wr_data[wr0 + 1], 32'h33334444);
        @(negedge CLK);
        dmemREN = 1'b1; dmemaddr = 32'h200;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (dhit || ramREN || ramWEN || !flushed) bad++;
            @(negedge CLK);
        end
        check("halted_quiet_cycles", 32'(bad), 32'd0);
        check("halted_rd_count", 32'(rd_cnt - rd0), 32'd0);
        dmemREN = 1'b0;

        // reset during write-back
        apply_reset();
        lat = 0;
        do_req(1'b0, 1'b1, 32'h100, 32'h77778888, cyc, load);
        check("rwb_write_miss_cycles", 32'(cyc), 32'd2);
        lat = 1000;
        wr0 = wr_cnt;
        @(negedge CLK);
        dmemREN = 1'b1; dmemWEN = 1'b0; dmemaddr = 32'h140;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rwb_in_wb_ramWEN", {31'd0, ramWEN}, 32'd1);
        check("rwb_in_wb_ramaddr", ramaddr, 32'h100);
        #2;
        nRST = 1'b0;
        #1;
        check("rwb_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("rwb_ramREN", {31'd0, ramREN}, 32'd0);
        check("rwb_ramaddr", ramaddr, 32'd0);
        check("rwb_ramstore", ramstore, 32'd0);
        check("rwb_dhit", {31'd0, dhit}, 32'd0);
        check("rwb_dmemload", dmemload, 32'd0);
        check("rwb_flushed", {31'd0, flushed}, 32'd0);
        @(negedge CLK);
        dmemREN = 1'b0;
        lat = 0;
        nRST = 1'b1;
        check("rwb_no_wr", 32'(wr_cnt - wr0), 32'd0);
        rd0 = rd_cnt;
        do_req(1'b1, 1'b0, 32'h100, 32'h0, cyc, load);
        check("rwb_reread_cycles", 32'(cyc), 32'd2);
        check("rwb_reread_rd", 32'(rd_cnt - rd0), 32'd1);
        check("rwb_reread_load", load, pat(32'h40));

        // randomized run against the transaction-level model
        apply_reset();
        lat = -1;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 0;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        for (int n = 0; n < 300; n++) begin
            int kind, t, ix, w, exp_cyc;
            logic ren, wen, hit, evict;
            logic [31:0] a, st;
            kind = int'($urandom_range(0, 2));
            ren = (kind != 1);
            wen = (kind != 0);
            t = int'($urandom_range(0, 7));
            ix = int'($urandom_range(0, 15));
            a = 32'(t * 64 + ix * 4);
            w = t * 16 + ix;
            st = $urandom;
            hit = m_valid[ix] && (m_tag[ix] == t);
            evict = !hit && m_valid[ix] && m_dirty[ix];
            wr0 = wr_cnt; rd0 = rd_cnt;
            do_req(ren, wen, a, st, cyc, load);
            exp_cyc = 0;
            if (!hit) exp_cyc = evict ? 3 + wr_lat[wr0] + rd_lat[rd0] : 2 + rd_lat[rd0];
            check("rnd_cycles", 32'(cyc), 32'(exp_cyc));
            check("rnd_wr_count", 32'(wr_cnt - wr0), evict ? 32'd1 : 32'd0);
            check("rnd_rd_count", 32'(rd_cnt - rd0), hit ? 32'd0 : 32'd1);
            if (evict) begin
                check("rnd_wb_addr", wr_addr[wr0], 32'(m_tag[ix] * 64 + ix * 4));
                check("rnd_wb_data", wr_data[wr0], ref_mem[m_tag[ix] * 16 + ix]);
            end
            if (!hit) check("rnd_fill_addr", rd_addr[rd0], a);
            if (!wen) check("rnd_load", load, ref_mem[w]);
            if (wen) ref_mem[w] = st;
            m_dirty[ix] = wen ? 1'b1 : (hit ? m_dirty[ix] : 1'b0);
            m_valid[ix] = 1'b1;
            m_tag[ix] = t;
            if (($urandom_range(0, 3)) == 0) begin
                @(negedge CLK);
                dmemREN = 1'b0; dmemWEN = 1'b0;
            end
        end
        @(negedge CLK);
        dmemREN = 1'b0; dmemWEN = 1'b0;
        check("ren_wen_exclusive", {31'd0, both_seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
